// File: rtl/seq_frame_sched_if.sv
// seq_frame_sched_if
//
// Bundles the register-side controls and the sequencer-side results of the
// SEQ frame scheduler. clk/reset stay plain ports on the module.
//
// Signal summary (direction as seen by the scheduler):
//   trst_i       in   single-cycle strobe: clear table write state and stop
//   tdat_i       in   table data word
//   tdat_wstb_i  in   write strobe for tdat_i
//   tlen_i       in   table length in frames (sampled on gate rising edge)
//   presc_i      in   clocks per tick (0 and 1 both mean every clock)
//   trepeat_i    in   table repeats, 0 = infinite
//   gate_i       in   level gate; rising edge starts, low stops
//   out_o        out  sequencer outputs
//   active_o     out  high in any state except IDLE
//   ovf_o        out  sticky table-overflow flag
//   cur_*_o      out  frame / fcycle / tcycle status
//   state_o      out  IDLE=0, LOAD=1, PHASE1=2, PHASE2=3
//
// Strobe semantics: there is no valid/ready back-pressure on this bus. Every
// strobe (trst_i, tdat_wstb_i) is acted on in the single clock in which it
// is sampled high; a table write that cannot be accepted is dropped and
// recorded in ovf_o rather than stalled.
interface seq_frame_sched_if;
   logic        trst_i;
   logic [31:0] tdat_i;
   logic        tdat_wstb_i;
   logic [15:0] tlen_i;
   logic [31:0] presc_i;
   logic [15:0] trepeat_i;
   logic        gate_i;
   logic [5:0]  out_o;
   logic        active_o;
   logic        ovf_o;
   logic [15:0] cur_frame_o;
   logic [15:0] cur_fcycle_o;
   logic [15:0] cur_tcycle_o;
   logic [1:0]  state_o;

   modport master (
      output trst_i, tdat_i, tdat_wstb_i, tlen_i, presc_i, trepeat_i, gate_i,
      input  out_o, active_o, ovf_o, cur_frame_o, cur_fcycle_o, cur_tcycle_o,
             state_o
   );

   modport slave (
      input  trst_i, tdat_i, tdat_wstb_i, tlen_i, presc_i, trepeat_i, gate_i,
      output out_o, active_o, ovf_o, cur_frame_o, cur_fcycle_o, cur_tcycle_o,
             state_o
   );
endinterface

// File: rtl/seq_frame_sched.sv
// seq_frame_sched
//
// Frame scheduler for the SEQ block. A register-loaded table of 3-word
// frames (W0 = repeat count, W1 = {out2[13:8], out1[5:0]},
// W2 = {p2 ticks, p1 ticks}) is played out onto a 6-bit output bus while the
// gate is high, with phase durations counted in prescaler ticks.
//
// Ports:
//   clk_i     system clock
//   reset_ni  asynchronous active-low reset
//   bus       seq_frame_sched_if.slave (register controls, outputs, status)
//
// Parameter:
//   DEPTH     table RAM depth in 32-bit words, power of 2
//
// Build option:
//   SEQ_SCHED_STATUS_EN  when defined, cur_frame_o/cur_fcycle_o/cur_tcycle_o
//                        and state_o report the scheduler counters and
//                        state; otherwise they are tied to 0. Scheduling is
//                        the same in both builds.
module seq_frame_sched #(
   parameter int DEPTH = 1024
) (
   input  logic            clk_i,
   input  logic            reset_ni,
   seq_frame_sched_if.slave bus
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_PHASE1 = 2'd2,
      S_PHASE2 = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic          active_q, active_d;
   logic          gate_prev_q;
   logic [AW:0]   wptr_q, wptr_d;
   logic [1:0]    wsub_q, wsub_d;      // word position inside the frame being written
   logic [15:0]   nframes_q, nframes_d;
   logic          ovf_q, ovf_d;
   logic [15:0]   len_q, len_d;
   logic [15:0]   frame_q, frame_d;
   logic [15:0]   fcycle_q, fcycle_d;
   logic [15:0]   tcycle_q, tcycle_d;
   logic [AW-1:0] base_q, base_d;      // RAM address of W0 of the current frame
   logic [1:0]    load_cnt_q, load_cnt_d;
   logic [15:0]   rep_q, rep_d;
   logic [15:0]   p1_q, p1_d;
   logic [15:0]   p2_q, p2_d;
   logic [5:0]    out1_q, out1_d;
   logic [5:0]    out2_q, out2_d;
   logic [5:0]    out_q, out_d;
   logic [31:0]   psc_cnt_q, psc_cnt_d;
   logic [15:0]   tick_cnt_q, tick_cnt_d;

   logic [31:0]   ram_q [DEPTH];
   logic [31:0]   rdata_q;
   logic [AW-1:0] raddr;
   logic          wr_en;
   logic          gate_rise;
   logic          run_ok;
   logic          tick;
   logic [15:0]   eff_len;
   logic [15:0]   p2_len;
   logic          frame_end;
   logic          enter_phase;
   logic          enter_p1_nz;

   // The top bit of wptr_q marks a full table (wptr == DEPTH).
   assign wr_en     = bus.tdat_wstb_i && !bus.trst_i && (state_q == S_IDLE) && !wptr_q[AW];
   assign gate_rise = bus.gate_i && !gate_prev_q;
   assign run_ok    = !bus.trst_i && bus.gate_i;
   assign eff_len   = (bus.tlen_i < nframes_q) ? bus.tlen_i : nframes_q;
   assign tick      = (bus.presc_i <= 32'd1) || (psc_cnt_q == bus.presc_i - 32'd1);
   // p1=p2=0 still plays one tick of out2.
   assign p2_len    = (p2_q == 16'd0) ? 16'd1 : p2_q;
   assign raddr     = base_q + AW'(load_cnt_q);

   // Table RAM: one write port from the register side, one synchronous read
   // port used only during LOAD.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         ram_q[wptr_q[AW-1:0]] <= bus.tdat_i;
      end
      rdata_q <= ram_q[raddr];
   end

   always_comb begin
      state_d     = state_q;
      wptr_d      = wptr_q;
      wsub_d      = wsub_q;
      nframes_d   = nframes_q;
      ovf_d       = ovf_q;
      len_d       = len_q;
      frame_d     = frame_q;
      fcycle_d    = fcycle_q;
      tcycle_d    = tcycle_q;
      base_d      = base_q;
      load_cnt_d  = load_cnt_q;
      rep_d       = rep_q;
      p1_d        = p1_q;
      p2_d        = p2_q;
      out1_d      = out1_q;
      out2_d      = out2_q;
      out_d       = out_q;
      psc_cnt_d   = psc_cnt_q;
      tick_cnt_d  = tick_cnt_q;
      frame_end   = 1'b0;
      enter_phase = 1'b0;
      enter_p1_nz = 1'b0;

      // Table write side. Frames written is tracked incrementally so no
      // divide-by-3 of the write pointer is needed.
      if (bus.trst_i) begin
         wptr_d    = '0;
         wsub_d    = 2'd0;
         nframes_d = 16'd0;
         ovf_d     = 1'b0;
      end else if (bus.tdat_wstb_i) begin
         if (wr_en) begin
            wptr_d = wptr_q + 1'b1;
            if (wsub_q == 2'd2) begin
               wsub_d    = 2'd0;
               nframes_d = nframes_q + 16'd1;
            end else begin
               wsub_d = wsub_q + 2'd1;
            end
         end else begin
            ovf_d = 1'b1;
         end
      end

      if (!run_ok) begin
         // Counters keep their values so software can read where it stopped.
         state_d = S_IDLE;
         out_d   = 6'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (gate_rise && (eff_len != 16'd0)) begin
                  state_d    = S_LOAD;
                  len_d      = eff_len;
                  frame_d    = 16'd0;
                  fcycle_d   = 16'd0;
                  tcycle_d   = 16'd0;
                  base_d     = '0;
                  load_cnt_d = 2'd0;
                  psc_cnt_d  = 32'd0;
               end
            end
            S_LOAD: begin
               // Reads are issued at load_cnt 0..2; each word lands one
               // clock later, so W2 is on rdata_q at load_cnt 3.
               load_cnt_d = load_cnt_q + 2'd1;
               case (load_cnt_q)
                  2'd1: rep_d = rdata_q[15:0];
                  2'd2: begin
                     out1_d = rdata_q[5:0];
                     out2_d = rdata_q[13:8];
                  end
                  2'd3: begin
                     p1_d        = rdata_q[15:0];
                     p2_d        = rdata_q[31:16];
                     enter_phase = 1'b1;
                     enter_p1_nz = (rdata_q[15:0] != 16'd0);
                  end
                  default: ;
               endcase
            end
            S_PHASE1: begin
               if (tick) begin
                  psc_cnt_d = 32'd0;
                  if (tick_cnt_q == p1_q - 16'd1) begin
                     tick_cnt_d = 16'd0;
                     if (p2_q != 16'd0) begin
                        state_d = S_PHASE2;
                        out_d   = out2_q;
                     end else begin
                        frame_end = 1'b1;
                     end
                  end else begin
                     tick_cnt_d = tick_cnt_q + 16'd1;
                  end
               end else begin
                  psc_cnt_d = psc_cnt_q + 32'd1;
               end
            end
            S_PHASE2: begin
               if (tick) begin
                  psc_cnt_d = 32'd0;
                  if (tick_cnt_q == p2_len - 16'd1) begin
                     tick_cnt_d = 16'd0;
                     frame_end  = 1'b1;
                  end else begin
                     tick_cnt_d = tick_cnt_q + 16'd1;
                  end
               end else begin
                  psc_cnt_d = psc_cnt_q + 32'd1;
               end
            end
            default: state_d = S_IDLE;
         endcase

         // End of a frame pass: repeat the frame, step to the next frame,
         // rewind the table, or finish.
         if (frame_end) begin
            if (({1'b0, fcycle_q} + 17'd1) < {1'b0, rep_q}) begin
               fcycle_d    = fcycle_q + 16'd1;
               enter_phase = 1'b1;
               enter_p1_nz = (p1_q != 16'd0);
            end else if (({1'b0, frame_q} + 17'd1) < {1'b0, len_q}) begin
               frame_d    = frame_q + 16'd1;
               fcycle_d   = 16'd0;
               base_d     = base_q + AW'(3);
               load_cnt_d = 2'd0;
               state_d    = S_LOAD;
            end else if ((bus.trepeat_i == 16'd0) ||
                         (({1'b0, tcycle_q} + 17'd1) < {1'b0, bus.trepeat_i})) begin
               tcycle_d   = tcycle_q + 16'd1;
               frame_d    = 16'd0;
               fcycle_d   = 16'd0;
               base_d     = '0;
               load_cnt_d = 2'd0;
               state_d    = S_LOAD;
            end else begin
               state_d = S_IDLE;
               out_d   = 6'd0;
            end
         end

         // Phase entry restarts the prescaler so every phase is n*presc clocks.
         if (enter_phase) begin
            psc_cnt_d  = 32'd0;
            tick_cnt_d = 16'd0;
            if (enter_p1_nz) begin
               state_d = S_PHASE1;
               out_d   = out1_q;
            end else begin
               state_d = S_PHASE2;
               out_d   = out2_q;
            end
         end
      end

      active_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q     <= S_IDLE;
         active_q    <= 1'b0;
         gate_prev_q <= 1'b0;
         wptr_q      <= '0;
         wsub_q      <= 2'd0;
         nframes_q   <= 16'd0;
         ovf_q       <= 1'b0;
         len_q       <= 16'd0;
         frame_q     <= 16'd0;
         fcycle_q    <= 16'd0;
         tcycle_q    <= 16'd0;
         base_q      <= '0;
         load_cnt_q  <= 2'd0;
         rep_q       <= 16'd0;
         p1_q        <= 16'd0;
         p2_q        <= 16'd0;
         out1_q      <= 6'd0;
         out2_q      <= 6'd0;
         out_q       <= 6'd0;
         psc_cnt_q   <= 32'd0;
         tick_cnt_q  <= 16'd0;
      end else begin
         state_q     <= state_d;
         active_q    <= active_d;
         gate_prev_q <= bus.gate_i;
         wptr_q      <= wptr_d;
         wsub_q      <= wsub_d;
         nframes_q   <= nframes_d;
         ovf_q       <= ovf_d;
         len_q       <= len_d;
         frame_q     <= frame_d;
         fcycle_q    <= fcycle_d;
         tcycle_q    <= tcycle_d;
         base_q      <= base_d;
         load_cnt_q  <= load_cnt_d;
         rep_q       <= rep_d;
         p1_q        <= p1_d;
         p2_q        <= p2_d;
         out1_q      <= out1_d;
         out2_q      <= out2_d;
         out_q       <= out_d;
         psc_cnt_q   <= psc_cnt_d;
         tick_cnt_q  <= tick_cnt_d;
      end
   end

   assign bus.out_o    = out_q;
   assign bus.active_o = active_q;
   assign bus.ovf_o    = ovf_q;

`ifdef SEQ_SCHED_STATUS_EN
   assign bus.cur_frame_o  = frame_q;
   assign bus.cur_fcycle_o = fcycle_q;
   assign bus.cur_tcycle_o = tcycle_q;
   assign bus.state_o      = state_q;
`else
   assign bus.cur_frame_o  = 16'd0;
   assign bus.cur_fcycle_o = 16'd0;
   assign bus.cur_tcycle_o = 16'd0;
   assign bus.state_o      = 2'd0;
`endif

endmodule

// File: tb/tb_seq_frame_sched.sv
// tb_seq_frame_sched
//
// Directed bench for seq_frame_sched. Instance dut uses DEPTH=1024 for the
// scheduling scenarios; instance dut16 uses DEPTH=16 for table-capacity and
// overflow scenarios. Status outputs are expected to read 0 unless the
// build defines SEQ_SCHED_STATUS_EN.
module tb_seq_frame_sched;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;

   logic [5:0] exp_q[$];
   logic [1:0] exp_st_q[$];

   seq_frame_sched_if b();
   seq_frame_sched_if b16();

   seq_frame_sched #(.DEPTH(1024)) dut (
      .clk_i    (clk),
      .reset_ni (rst_n),
      .bus      (b)
   );

   seq_frame_sched #(.DEPTH(16)) dut16 (
      .clk_i    (clk),
      .reset_ni (rst_n),
      .bus      (b16)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] stat(input logic [31:0] v);
`ifdef SEQ_SCHED_STATUS_EN
      return v;
`else
      return 32'd0;
`endif
   endfunction

   task automatic write_main(input logic [31:0] d);
      b.tdat_i      = d;
      b.tdat_wstb_i = 1'b1;
      tick(1);
      b.tdat_wstb_i = 1'b0;
   endtask

   task automatic write16(input logic [31:0] d);
      b16.tdat_i      = d;
      b16.tdat_wstb_i = 1'b1;
      tick(1);
      b16.tdat_wstb_i = 1'b0;
   endtask

   task automatic push_run(input logic [5:0] v, input logic [1:0] st, input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(v);
         exp_st_q.push_back(st);
      end
   endtask

   // Compares out_o/state_o against the expected queues, one entry per clock.
   task automatic check_run(input string tag);
      logic [5:0] e;
      logic [1:0] s;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         s = exp_st_q.pop_front();
         check({tag, "_out"}, {26'd0, b.out_o}, {26'd0, e});
         check({tag, "_state"}, {30'd0, b.state_o}, stat({30'd0, s}));
         tick(1);
      end
   endtask

   // DEPTH=16 table contents: frame k = {1, k+1, p1=1/p2=0}
   function automatic logic [31:0] word16(input int i);
      int k;
      k = i / 3;
      case (i % 3)
         0:       return 32'd1;
         1:       return 32'(k + 1);
         default: return 32'h0000_0001;
      endcase
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      b.trst_i = 1'b0;   b.tdat_i = '0;   b.tdat_wstb_i = 1'b0;
      b.tlen_i = '0;     b.presc_i = '0;  b.trepeat_i = '0;  b.gate_i = 1'b0;
      b16.trst_i = 1'b0; b16.tdat_i = '0; b16.tdat_wstb_i = 1'b0;
      b16.tlen_i = '0;   b16.presc_i = '0; b16.trepeat_i = '0; b16.gate_i = 1'b0;

      // reset values
      tick(2);
      check("rst_out",    {26'd0, b.out_o}, 32'd0);
      check("rst_active", {31'd0, b.active_o}, 32'd0);
      check("rst_ovf",    {31'd0, b.ovf_o}, 32'd0);
      check("rst_state",  {30'd0, b.state_o}, stat(32'd0));
      check("rst_frame",  {16'd0, b.cur_frame_o}, 32'd0);
      check("rst_fcycle", {16'd0, b.cur_fcycle_o}, 32'd0);
      check("rst_tcycle", {16'd0, b.cur_tcycle_o}, 32'd0);
      check("rst16_ovf",  {31'd0, b16.ovf_o}, 32'd0);
      rst_n = 1'b1;
      tick(1);

      // two-frame table
      write_main(32'd2); write_main(32'h0000_0201); write_main(32'h0002_0003);
      write_main(32'd1); write_main(32'h0000_0004); write_main(32'h0001_0001);
      check("load_ovf", {31'd0, b.ovf_o}, 32'd0);
      b.presc_i = 32'd1; b.trepeat_i = 16'd1; b.tlen_i = 16'd2;

      // two-frame run, presc=1
      push_run(6'h01, 2'd2, 3); push_run(6'h02, 2'd3, 2);
      push_run(6'h01, 2'd2, 3); push_run(6'h02, 2'd3, 2);
      push_run(6'h02, 2'd1, 4);
      push_run(6'h04, 2'd2, 1); push_run(6'h00, 2'd3, 1);
      b.gate_i = 1'b1;
      tick(1);
      check("t1_load_state", {30'd0, b.state_o}, stat(32'd1));
      check("t1_load_active", {31'd0, b.active_o}, 32'd1);
      tick(4);
      check_run("t1");
      check("t1_end_state",  {30'd0, b.state_o}, stat(32'd0));
      check("t1_end_active", {31'd0, b.active_o}, 32'd0);
      check("t1_end_out",    {26'd0, b.out_o}, 32'd0);
      check("t1_end_frame",  {16'd0, b.cur_frame_o}, stat(32'd1));
      check("t1_end_tcycle", {16'd0, b.cur_tcycle_o}, stat(32'd0));
      b.gate_i = 1'b0;
      tick(2);

      // same table, presc=3
      b.presc_i = 32'd3;
      push_run(6'h01, 2'd2, 9); push_run(6'h02, 2'd3, 6);
      push_run(6'h01, 2'd2, 9); push_run(6'h02, 2'd3, 6);
      push_run(6'h02, 2'd1, 4);
      push_run(6'h04, 2'd2, 3); push_run(6'h00, 2'd3, 3);
      b.gate_i = 1'b1;
      tick(5);
      check_run("t2");
      check("t2_end_active", {31'd0, b.active_o}, 32'd0);
      b.gate_i = 1'b0;
      tick(2);

      // gate dropped on 2nd clock of F0 PHASE2, then restart
      b.presc_i = 32'd1;
      b.gate_i = 1'b1;
      tick(9);
      check("t3_p2_out", {26'd0, b.out_o}, 32'd2);
      b.gate_i = 1'b0;
      tick(1);
      check("t3_drop_out",    {26'd0, b.out_o}, 32'd0);
      check("t3_drop_active", {31'd0, b.active_o}, 32'd0);
      check("t3_drop_state",  {30'd0, b.state_o}, stat(32'd0));
      check("t3_drop_frame",  {16'd0, b.cur_frame_o}, stat(32'd0));
      b.gate_i = 1'b1;
      tick(1);
      check("t3_re_state",  {30'd0, b.state_o}, stat(32'd1));
      check("t3_re_fcycle", {16'd0, b.cur_fcycle_o}, stat(32'd0));
      tick(4);
      check("t3_re_out", {26'd0, b.out_o}, 32'd1);
      tick(5);
      check("t3_re_fcycle1", {16'd0, b.cur_fcycle_o}, stat(32'd1));
      b.gate_i = 1'b0;
      tick(2);

      // tlen=0: gate edge ignored
      b.tlen_i = 16'd0;
      b.gate_i = 1'b1;
      tick(2);
      check("t4_active", {31'd0, b.active_o}, 32'd0);
      check("t4_state",  {30'd0, b.state_o}, stat(32'd0));
      b.gate_i = 1'b0;
      tick(2);

      // trepeat=0, single frame with p2=0
      b.trst_i = 1'b1;
      tick(1);
      b.trst_i = 1'b0;
      write_main(32'd1); write_main(32'h0000_0301); write_main(32'h0000_0001);
      b.tlen_i = 16'd1; b.trepeat_i = 16'd0;
      b.gate_i = 1'b1;
      tick(5);
      check("t6_p5_out",    {26'd0, b.out_o}, 32'd1);
      check("t6_p5_state",  {30'd0, b.state_o}, stat(32'd2));
      check("t6_p5_tcycle", {16'd0, b.cur_tcycle_o}, stat(32'd0));
      tick(1);
      check("t6_p6_out",    {26'd0, b.out_o}, 32'd1);
      check("t6_p6_state",  {30'd0, b.state_o}, stat(32'd1));
      check("t6_p6_tcycle", {16'd0, b.cur_tcycle_o}, stat(32'd1));
      tick(4);
      check("t6_p10_out",   {26'd0, b.out_o}, 32'd1);
      check("t6_p10_state", {30'd0, b.state_o}, stat(32'd2));
      tick(1);
      check("t6_p11_tcycle", {16'd0, b.cur_tcycle_o}, stat(32'd2));
      check("t6_p11_active", {31'd0, b.active_o}, 32'd1);
      b.gate_i = 1'b0;
      tick(1);
      check("t6_stop_out",    {26'd0, b.out_o}, 32'd0);
      check("t6_stop_active", {31'd0, b.active_o}, 32'd0);
      check("t6_stop_tcycle", {16'd0, b.cur_tcycle_o}, stat(32'd2));

      // DEPTH=16: capacity and overflow
      b16.presc_i = 32'd1; b16.trepeat_i = 16'd1; b16.tlen_i = 16'd16;
      for (int i = 0; i < 16; i++) write16(word16(i));
      check("d16_ovf_16w", {31'd0, b16.ovf_o}, 32'd0);
      write16(word16(16));
      check("d16_ovf_17w", {31'd0, b16.ovf_o}, 32'd1);
      b16.gate_i = 1'b1;
      tick(5);
      check("d16_f0_out", {26'd0, b16.out_o}, 32'd1);
      tick(20);
      check("d16_f4_out",   {26'd0, b16.out_o}, 32'd5);
      check("d16_f4_state", {30'd0, b16.state_o}, stat(32'd2));
      tick(1);
      check("d16_end_active", {31'd0, b16.active_o}, 32'd0);
      check("d16_end_frame",  {16'd0, b16.cur_frame_o}, stat(32'd4));
      b16.gate_i = 1'b0;
      tick(2);
      b16.trst_i = 1'b1;
      tick(1);
      b16.trst_i = 1'b0;
      check("d16_trst_ovf", {31'd0, b16.ovf_o}, 32'd0);
      b16.gate_i = 1'b1;
      tick(2);
      check("d16_empty_active", {31'd0, b16.active_o}, 32'd0);
      b16.gate_i = 1'b0;
      tick(2);
      write16(32'd1); write16(32'h0000_0007); write16(32'h0000_0004);
      check("d16_rewrite_ovf", {31'd0, b16.ovf_o}, 32'd0);
      b16.gate_i = 1'b1;
      tick(5);
      check("d16_p1_out", {26'd0, b16.out_o}, 32'd7);
      write16(32'hDEAD_BEEF);
      check("d16_busy_ovf", {31'd0, b16.ovf_o}, 32'd1);
      check("d16_busy_out", {26'd0, b16.out_o}, 32'd7);
      b16.gate_i = 1'b0;
      tick(1);
      check("d16_stop_out", {26'd0, b16.out_o}, 32'd0);

      // ---------------- report ----------------
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_frame_sched.md
# seq_frame_sched

Frame scheduler for the SEQ block. It holds a register-loaded table of frames and steps through them under control of the gate input. Each frame's repeat count, two output phases and phase durations are applied to a 6-bit output bus, timed by a programmable prescaler. It sits between the AXI register decode (TRST/TDAT/TLEN/PRESC/TREPEAT/SGATE strobes) and the sequencer outputs on the position/bit bus, and publishes CUR_FRAME/CUR_FCYCLE/CUR_TCYCLE/STATE status.

## Interface
- `DEPTH`, 1024: table RAM depth in 32-bit words; power of 2. Frame capacity is `DEPTH/3` frames, rounded down.
- `clk_i` in 1: system clock (FCLK domain).
- `reset_ni` in 1: reset, asynchronous, active-low.
- `trst_i` in 1: single-cycle strobe; clears write pointer, `ovf_o` and frames-written count; forces IDLE.
- `tdat_i` in 32: table data word.
- `tdat_wstb_i` in 1: write strobe for `tdat_i`.
- `tlen_i` in 16: table length in frames. Sampled on each gate rising edge.
- `presc_i` in 32: clocks per tick; 0 and 1 both mean one tick every clock.
- `trepeat_i` in 16: table repeats; 0 means infinite.
- `gate_i` in 1: level; the rising edge starts a run, low forces IDLE.
- `out_o` out 6: sequencer outputs.
- `active_o` out 1: high in any state except IDLE.
- `ovf_o` out 1: sticky table-overflow flag.
- `cur_frame_o` out 16, `cur_fcycle_o` out 16, `cur_tcycle_o` out 16: status.
- `state_o` out 2: IDLE=0, LOAD=1, PHASE1=2, PHASE2=3.

## Operation
- Frame layout: three consecutive words.
  - W0 = repeat count (bits [15:0]; 0 is treated as 1).
  - W1 = {out2 [13:8], out1 [5:0]}.
  - W2 = {p2 ticks [31:16], p1 ticks [15:0]}.
- Table write:
  - `tdat_wstb_i` in IDLE writes RAM[wptr] and increments wptr.
  - A write at wptr=DEPTH is dropped and sets `ovf_o`.
  - Writes outside IDLE are dropped and set `ovf_o`.
  - Frames written = wptr/3.
- Effective length L = min(`tlen_i`, frames written). A gate rising edge with L=0 is ignored; the block stays in IDLE.
- FSM:
  - IDLE -> LOAD on a gate rising edge with L>0. The frame index, fcycle and tcycle counters are cleared, and the prescaler is reset.
  - LOAD: three RAM reads with 1-cycle read latency, so LOAD lasts 4 clocks. `out_o` holds its previous value during LOAD. LOAD -> PHASE1.
  - PHASE1: `out_o`=out1 for p1 ticks, then -> PHASE2. If p1=0, PHASE1 is skipped.
  - PHASE2: `out_o`=out2 for p2 ticks. At its end:
    - fcycle+1 < repeat: fcycle++, -> PHASE1 without reload.
    - Otherwise, if frame+1 < L: frame++, fcycle=0, -> LOAD.
    - Otherwise, if `trepeat_i`=0 or tcycle+1 < `trepeat_i`: tcycle++, frame=0, -> LOAD.
    - Otherwise -> IDLE.
  - If p1=p2=0, the frame occupies one tick, with `out_o`=out2.
- Prescaler:
  - A counter runs in PHASE1/PHASE2 and emits a tick when count reaches presc-1, then clears.
  - It clears on every phase entry, so each phase lasts exactly n×presc clocks.
- `gate_i` low in any state: IDLE on the next clock, `out_o`=0, counters hold their values for readback. The next rising edge restarts from frame 0.
- `trst_i` has priority over `gate_i`. `trst_i` and `tdat_wstb_i` in the same cycle: reset wins and the word is dropped.
- Status outputs: `cur_frame_o`=frame, `cur_fcycle_o`=fcycle, `cur_tcycle_o`=tcycle, all 0-based.

## Timing
- Reset values: `out_o`=0, `active_o`=0, `ovf_o`=0, all status outputs 0, `state_o`=IDLE, wptr=0.
- Gate edge detection uses a registered previous value of `gate_i`:
  - clock N samples `gate_i`=1 -> LOAD at N+1.
  - PHASE1 `out_o` is valid at N+5.
- Phase transitions are registered: `out_o` changes on the clock after the terminal tick.
- `gate_i` low sampled at clock N -> `out_o`=0 and `state_o`=IDLE at N+1.
- RAM write data is visible to reads 1 clock after the strobe.

## Configuration
- `SEQ_SCHED_STATUS_EN` defined: `cur_frame_o`, `cur_fcycle_o`, `cur_tcycle_o` and `state_o` are driven as specified.
- `SEQ_SCHED_STATUS_EN` undefined: those four outputs are tied to 0 and the status registers are removed. Scheduling behaviour is identical.

## Test plan
- Two-frame run, presc=1, trepeat=1, tlen=2:
  - Stimulus:
    - F0 = {2, 0x0201, 0x0002_0003}.
    - F1 = {1, 0x0004, 0x0001_0001}.
  - Required response:
    - `out_o` from gate+5: 01×3, 02×2, 01×3, 02×2.
    - Then 4 clocks holding 02, then 04×1, 00×1.
    - Then IDLE with `cur_tcycle_o`=0 and `cur_frame_o`=1.
- Same table with presc=3: every phase is 3× longer (01 lasts 9 clocks); LOAD is still 4 clocks.
- Gate dropped at the 2nd clock of F0 PHASE2: IDLE and `out_o`=0 the next clock. Re-raising the gate restarts at frame 0, fcycle 0.
- `tlen_i`=0 or no frames written: gate rising edge leaves `state_o`=0 and `active_o`=0.
- DEPTH=16:
  - Writing 17 words: `ovf_o`=1, and frames written = 5.
  - `trst_i` clears `ovf_o`.
  - A TDAT write during PHASE1 sets `ovf_o`.
- trepeat=0 with a single frame {1, 0x0301, 0x0000_0001}: PHASE2 is skipped and `out_o` loops 01 with 4-clock holds. `cur_tcycle_o` increments until the gate falls.
